// File: rtl/ro_puf_response_ctrl.sv
// ro_puf_response_ctrl
// Runs one race per response bit on the dual race counter and collects the
// results into a RESP_BITS-wide PUF response. For each bit it selects an
// oscillator pair, clears the counter pair, enables the race, and records
// which counter finished first. The finished word is held until the consumer
// acknowledges it.
//
// Ports
//   clk, rst      : clock; synchronous active-high reset
//   start         : begin a run (looked at only while idle)
//   finish[1:0]   : counter goal pulses, [0] = osc A, [1] = osc B
//   race_rst      : counter-pair clear (also high while rst is high)
//   race_en       : gates both oscillators into the counters
//   pair_sel      : index of the oscillator pair under test
//   busy          : high outside IDLE
//   resp          : response word, bit i from the race on pair i
//   resp_valid    : resp and flags are valid (held until resp_ack)
//   resp_ack      : consumer accepts the response
//   tie_seen      : sticky, some race in this run tied
//   timeout_seen  : sticky, some race in this run timed out
module ro_puf_response_ctrl #(
  parameter int RESP_BITS  = 16,
  parameter int SEL_W      = 4,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 1023,
  parameter bit TIE_VAL    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           finish,
  output logic                 race_rst,
  output logic                 race_en,
  output logic [SEL_W-1:0]     pair_sel,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ack,
  output logic                 tie_seen,
  output logic                 timeout_seen
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RACE  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0]       CLR_LAST = 4'(CLR_CYCLES - 1);
  localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(RESP_BITS - 1);

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       pair_sel_q, pair_sel_d;   // doubles as the bit index
  logic [RESP_BITS-1:0]   resp_q, resp_d;
  logic                   tie_q, tie_d;
  logic                   to_q, to_d;
  logic [3:0]             clr_cnt_q, clr_cnt_d;
  logic [15:0]            timer_q, timer_d;
  logic                   bit_q, bit_d;             // result of the last race

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pair_sel_q <= '0;
      resp_q     <= '0;
      tie_q      <= 1'b0;
      to_q       <= 1'b0;
      clr_cnt_q  <= '0;
      timer_q    <= '0;
      bit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pair_sel_q <= pair_sel_d;
      resp_q     <= resp_d;
      tie_q      <= tie_d;
      to_q       <= to_d;
      clr_cnt_q  <= clr_cnt_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: if (clr_cnt_q == CLR_LAST) state_d = S_RACE;
      // Any finish pulse or the last allowed race cycle ends the race.
      S_RACE:  if ((finish != 2'b00) || (timer_q == TO_LAST)) state_d = S_STORE;
      S_STORE: state_d = (pair_sel_q == SEL_LAST) ? S_DONE : S_CLEAR;
      // start is not looked at here, so start+ack together just returns to IDLE.
      S_DONE:  if (resp_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    pair_sel_d = pair_sel_q;
    resp_d     = resp_q;
    tie_d      = tie_q;
    to_d       = to_q;
    clr_cnt_d  = clr_cnt_q;
    timer_d    = timer_q;
    bit_d      = bit_q;
    case (state_q)
      S_IDLE: begin
        // resp is kept in IDLE and only wiped when a new run begins.
        if (start) begin
          pair_sel_d = '0;
          resp_d     = '0;
          tie_d      = 1'b0;
          to_d       = 1'b0;
          clr_cnt_d  = '0;
        end
      end
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 4'd1;
        if (clr_cnt_q == CLR_LAST) timer_d = '0;
      end
      S_RACE: begin
        timer_d = timer_q + 16'd1;
        // A finish pulse wins over a timeout that falls on the same cycle.
        case (finish)
          2'b01: bit_d = 1'b0;
          2'b10: bit_d = 1'b1;
          2'b11: begin
            bit_d = TIE_VAL;
            tie_d = 1'b1;
          end
          default: begin
            if (timer_q == TO_LAST) begin
              bit_d = 1'b0;
              to_d  = 1'b1;
            end
          end
        endcase
      end
      S_STORE: begin
        for (int i = 0; i < RESP_BITS; i++) begin
          if (pair_sel_q == SEL_W'(i)) resp_d[i] = bit_q;
        end
        // pair_sel only moves here (race_en low), never during a race.
        if (pair_sel_q != SEL_LAST) begin
          pair_sel_d = pair_sel_q + SEL_W'(1);
          clr_cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // rst feeds race_rst directly so the counters are cleared during reset.
    race_rst   = rst | (state_q == S_CLEAR);
    race_en    = (state_q == S_RACE);
    busy       = (state_q != S_IDLE);
    resp_valid = (state_q == S_DONE);
  end

  assign pair_sel     = pair_sel_q;
  assign resp         = resp_q;
  assign tie_seen     = tie_q;
  assign timeout_seen = to_q;

endmodule

// File: tb/tb_ro_puf_response_ctrl.sv
// Testbench for ro_puf_response_ctrl (RESP_BITS=4, CLR_CYCLES=2, TIMEOUT=8).
// Each run pushes its hand-computed response and flags into a scoreboard
// queue; a monitor pops and compares whenever resp_valid rises.
module tb_ro_puf_response_ctrl;
  localparam int RB  = 4;
  localparam int SW  = 2;
  localparam int CLR = 2;
  localparam int TO  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    finish = 2'b00;
  logic          resp_ack = 1'b0;
  logic          race_rst, race_en, busy, resp_valid, tie_seen, timeout_seen;
  logic [SW-1:0] pair_sel;
  logic [RB-1:0] resp;

  int errors = 0;
  int checks = 0;
  logic [5:0] sb_q[$];   // {resp, tie_seen, timeout_seen}
  logic vld_prev = 1'b0;

  ro_puf_response_ctrl #(
    .RESP_BITS(RB), .SEL_W(SW), .CLR_CYCLES(CLR), .TIMEOUT(TO), .TIE_VAL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .race_rst(race_rst), .race_en(race_en), .pair_sel(pair_sel), .busy(busy),
    .resp(resp), .resp_valid(resp_valid), .resp_ack(resp_ack),
    .tie_seen(tie_seen), .timeout_seen(timeout_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [5:0] e;
    if (resp_valid && !vld_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: resp=%b while no response was expected", resp);
      end else begin
        e = sb_q.pop_front();
        chk("resp", int'(resp), int'(e[5:2]));
        chk("tie_seen", int'(tie_seen), int'(e[1]));
        chk("timeout_seen", int'(timeout_seen), int'(e[0]));
      end
    end
    vld_prev = resp_valid;
  end

  // One bit: count clear cycles, then drive finish=f on race cycle r.
  // junk drives finish=11 outside RACE and start=1 inside RACE.
  task automatic race_bit(input int idx, input logic [1:0] f, input int r, input bit junk);
    int n = 0;
    int g = 0;
    int rc = 0;
    int sel_ok = 1;
    while (!race_en && g < 50) begin
      if (race_rst) n++;
      finish = junk ? 2'b11 : 2'b00;
      @(negedge clk);
      g++;
    end
    chk($sformatf("clr_cycles_bit%0d", idx), n, CLR);
    g = 0;
    while (race_en && g < 300) begin
      rc++;
      if (pair_sel != SW'(idx)) sel_ok = 0;
      finish = (rc == r) ? f : 2'b00;
      start  = junk;
      @(negedge clk);
      g++;
    end
    finish = junk ? 2'b11 : 2'b00;
    start  = 1'b0;
    chk($sformatf("race_cycles_bit%0d", idx), rc, (r <= TO) ? r : TO);
    chk($sformatf("pair_sel_bit%0d", idx), sel_ok, 1);
  endtask

  task automatic wait_valid();
    int g = 0;
    finish = 2'b00;
    while (!resp_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("done_reached", int'(resp_valid), 1);
  endtask

  task automatic do_run(input logic [3:0][1:0] f, input logic [3:0][7:0] r,
                        input logic [3:0] er, input bit et, input bit eto, input bit junk);
    sb_q.push_back({er, et, eto});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < RB; i++) race_bit(i, f[i], int'(r[i]), junk);
    wait_valid();
  endtask

  task automatic ack();
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    chk("valid_drop_on_ack", int'(resp_valid), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [RB-1:0] r0;
    int g;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_race_rst", int'(race_rst), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_race_en", int'(race_en), 0);
    chk("rst_resp", int'(resp), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_pair_sel", int'(pair_sel), 0);
    chk("rst_tie", int'(tie_seen), 0);
    chk("rst_timeout", int'(timeout_seen), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_race_rst", int'(race_rst), 0);

    // Normal run: bits 1,0,1,0 -> 4'b0101, then handshake hold
    do_run({2'b01, 2'b10, 2'b01, 2'b10}, {8'd5, 8'd5, 8'd5, 8'd5}, 4'b0101, 1'b0, 1'b0, 1'b0);
    r0 = resp;
    for (int k = 0; k < 10; k++) begin
      start = (k == 3);
      @(negedge clk);
      chk("hold_valid", int'(resp_valid), 1);
      chk("hold_resp", int'(resp), int'(r0));
    end
    start = 1'b0;
    ack();
    chk("idle_after_ack", int'(busy), 0);
    chk("resp_kept_in_idle", int'(resp), 4'b0101);

    // Tie on bit 2 -> 4'b0001, tie_seen; then start+ack together
    do_run({2'b01, 2'b11, 2'b01, 2'b10}, {8'd3, 8'd3, 8'd3, 8'd3}, 4'b0001, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    resp_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    resp_ack = 1'b0;
    chk("start_ack_valid", int'(resp_valid), 0);
    chk("start_ack_idle", int'(busy), 0);
    @(negedge clk);
    chk("start_ack_stays_idle", int'(busy), 0);

    // Clean run with junk finish/start pulses -> 4'b1010, tie cleared
    do_run({2'b10, 2'b01, 2'b10, 2'b01}, {8'd2, 8'd2, 8'd2, 8'd2}, 4'b1010, 1'b0, 1'b0, 1'b1);
    ack();

    // Timeout on bit 1 -> 4'b1101, timeout_seen
    do_run({2'b10, 2'b10, 2'b00, 2'b10}, {8'd4, 8'd4, 8'd100, 8'd4}, 4'b1101, 1'b0, 1'b1, 1'b0);
    ack();

    // Finish on the 8th (timeout) cycle of bit 1 wins -> 4'b0010
    do_run({2'b01, 2'b01, 2'b10, 2'b01}, {8'd6, 8'd6, 8'd8, 8'd6}, 4'b0010, 1'b0, 1'b0, 1'b0);
    ack();

    // Reset during RACE of bit 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    race_bit(0, 2'b10, 3, 1'b0);
    race_bit(1, 2'b10, 3, 1'b0);
    g = 0;
    while (!race_en && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("abort_in_race_bit2", int'(race_en && (pair_sel == 2'd2)), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_race_en", int'(race_en), 0);
    chk("abort_race_rst", int'(race_rst), 1);
    chk("abort_resp", int'(resp), 0);
    chk("abort_pair_sel", int'(pair_sel), 0);
    @(negedge clk);
    chk("abort_race_rst_held", int'(race_rst), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_released_race_rst", int'(race_rst), 0);
    chk("abort_no_valid", int'(resp_valid), 0);

    // Fresh run after abort restarts at pair 0 -> 4'b1111
    do_run({2'b10, 2'b10, 2'b10, 2'b10}, {8'd1, 8'd1, 8'd1, 8'd1}, 4'b1111, 1'b0, 1'b0, 1'b0);
    ack();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
